// File: rtl/fifo_reader_disp.sv
// fifo_reader_disp: drains a show-ahead FIFO one byte per read tick and shows
// the last consumed byte and the consumed-byte count on a 4-digit multiplexed
// 7-segment display (digits 1:0 = last_byte, digits 3:2 = rd_count, hex).
// Optional feature: define FIFO_READER_EMPTY_DP_EN to light the digit-0
// decimal point while the upstream FIFO reports empty.
module fifo_reader_disp #(
   parameter int TICK_DIV = 100000000,  // clk cycles per read opportunity (>=4)
   parameter int SCAN_DIV = 50000       // clk cycles each digit is driven (>=1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd_en,
   input  logic       empty,
   input  logic [7:0] fifo_dout,
   output logic       rd,
   output logic [7:0] last_byte,
   output logic [7:0] rd_count,
   output logic [3:0] wei,
   output logic [7:0] duan
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              gap_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        digit;
   logic [3:0]        nibble;
   logic              dp_nxt;

   // Standard hex glyphs, segment order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   endfunction

   assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

   // Free-running read-opportunity divider, independent of the FSM.
   always_ff @(posedge clk) begin
      // NOTE: clocked state is assigned with <= so every register samples the
      // pre-edge values; blocking here would make results depend on order.
      if (rst || tick) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + 1'b1;
   end

   // FSM state register; gap_cnt stretches GAP to exactly two cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gap_cnt <= 1'b0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= (state == GAP) ? ~gap_cnt : 1'b0;
      end
   end

   // Next-state logic: empty and tick only matter in IDLE, so ticks seen in
   // READ/GAP are simply dropped.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned
      // (which would infer a latch).
      state_nxt = state;
      case (state)
         IDLE:    if (tick && rd_en && !empty) state_nxt = READ;
         READ:    state_nxt = GAP;
         GAP:     if (gap_cnt) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: the read strobe is exactly the READ state.
   always_comb begin
      rd = (state == READ);
   end

   // Capture the consumed byte and bump the count at the end of READ;
   // reset wins over a read in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_byte <= 8'h00;
         rd_count  <= 8'h00;
      end else if (state == READ) begin
         last_byte <= fifo_dout;
         rd_count  <= rd_count + 8'd1;
      end
   end

   // Digit scan: advance the digit index every SCAN_DIV cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         digit    <= 2'd0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         digit    <= digit + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Select the nibble shown on the current digit.
   always_comb begin
      nibble = last_byte[3:0];
      case (digit)
         2'd0: nibble = last_byte[3:0];
         2'd1: nibble = last_byte[7:4];
         2'd2: nibble = rd_count[3:0];
         default: nibble = rd_count[7:4];
      endcase
   end

`ifdef FIFO_READER_EMPTY_DP_EN
   assign dp_nxt = (digit == 2'd0) && empty;
`else
   assign dp_nxt = 1'b0;
`endif

   // Registered digit select and segments, updated on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wei  <= 4'b0001;
         duan <= 8'h3F;
      end else begin
         wei  <= 4'b0001 << digit;
         duan <= {dp_nxt, seg7(nibble)};
      end
   end

endmodule

// File: tb/tb_fifo_reader_disp.sv
// Testbench for fifo_reader_disp: a queue-based FIFO environment, a
// cycle-count reference model, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_fifo_reader_disp;

   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rd_en = 1'b0;
   logic       empty = 1'b1;
   logic [7:0] fifo_dout = 8'h00;
   logic       rd;
   logic [7:0] last_byte;
   logic [7:0] rd_count;
   logic [3:0] wei;
   logic [7:0] duan;

   fifo_reader_disp #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .empty     (empty),
      .fifo_dout (fifo_dout),
      .rd        (rd),
      .last_byte (last_byte),
      .rd_count  (rd_count),
      .wei       (wei),
      .duan      (duan)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   byte unsigned fifo_q[$];
   bit           pop_pending = 1'b0;

   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model: everything follows from the number of cycles since
   // reset (tick and digit position) plus a "busy" countdown of 3 cycles
   // (one read cycle, two settle cycles) started by an accepted tick.
   bit         m_valid = 1'b0;
   int         cyc = 0;
   int         hold = 0;
   logic [7:0] m_lb = 8'h00;
   logic [7:0] m_cnt = 8'h00;
   logic [3:0] m_wei = 4'b0001;
   logic [7:0] m_duan = 8'h3F;

   function automatic int digit_of(input int c);
      return (c / SCAN_DIV) % 4;
   endfunction

   function automatic logic [6:0] exp_seg(input int c, input logic [7:0] lb, input logic [7:0] cnt);
      logic [3:0] n;
      case (digit_of(c))
         0: n = lb[3:0];
         1: n = lb[7:4];
         2: n = cnt[3:0];
         default: n = cnt[7:4];
      endcase
      return GLYPH[n];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b1;
         cyc     <= 0;
         hold    <= 0;
         m_lb    <= 8'h00;
         m_cnt   <= 8'h00;
         m_wei   <= 4'b0001;
         m_duan  <= 8'h3F;
      end else if (m_valid) begin
         m_wei <= 4'b0001 << digit_of(cyc);
`ifdef FIFO_READER_EMPTY_DP_EN
         m_duan <= {(digit_of(cyc) == 0) && empty, exp_seg(cyc, m_lb, m_cnt)};
`else
         m_duan <= {1'b0, exp_seg(cyc, m_lb, m_cnt)};
`endif
         if (hold == 3) begin
            m_lb  <= fifo_dout;
            m_cnt <= m_cnt + 8'd1;
         end
         if (hold > 0)
            hold <= hold - 1;
         else if ((cyc % TICK_DIV) == TICK_DIV - 1 && rd_en && !empty)
            hold <= 3;
         cyc <= cyc + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: compare against the model at the falling edge, then let the
   // FIFO environment pop on a completed read and present the next head.
   task automatic step();
      @(negedge clk);
      if (m_valid) begin
         check("rd",        32'(rd),        32'(hold == 3));
         check("last_byte", 32'(last_byte), 32'(m_lb));
         check("rd_count",  32'(rd_count),  32'(m_cnt));
         check("wei",       32'(wei),       32'(m_wei));
         check("duan",      32'(duan),      32'(m_duan));
      end
      if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pending = (rd === 1'b1);
      empty = (fifo_q.size() == 0);
      fifo_dout = empty ? 8'($urandom) : fifo_q[0];
   endtask

   task automatic wait_rd(input string name, input int budget, output int n);
      n = 0;
      while (rd !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(name, 32'(rd === 1'b1), 32'd1);
   endtask

   task automatic wait_wei(input logic [3:0] target, input int budget);
      int n = 0;
      while (wei !== target && n < budget) begin
         step();
         n++;
      end
      check("wei_reached", 32'(wei), 32'(target));
   endtask

   initial begin
      int n;
      int rd_seen;

      // Reset state.
      rst = 1'b1;
      step();
      step();
      check("rst_rd",        32'(rd),        32'd0);
      check("rst_last_byte", 32'(last_byte), 32'h00);
      check("rst_rd_count",  32'(rd_count),  32'h00);
      check("rst_wei",       32'(wei),       32'b0001);
      check("rst_duan",      32'(duan),      32'h3F);
      rst = 1'b0;

      // Empty FIFO with reads enabled: nothing is consumed.
      rd_en = 1'b1;
      rd_seen = 0;
      repeat (40) begin
         step();
         if (rd === 1'b1) rd_seen++;
      end
      check("empty_no_rd", 32'(rd_seen), 32'd0);
      check("empty_count", 32'(rd_count), 32'h00);

      // Two preloaded bytes: two single reads four cycles apart.
      fifo_q.push_back(8'hA5);
      fifo_q.push_back(8'h3C);
      wait_rd("first_rd", 12, n);
      step();
      check("first_byte",  32'(last_byte), 32'hA5);
      check("first_count", 32'(rd_count),  32'd1);
      wait_rd("second_rd", 12, n);
      check("rd_spacing", 32'(n + 1), 32'd4);
      step();
      check("second_byte",  32'(last_byte), 32'h3C);
      check("second_count", 32'(rd_count),  32'd2);
      rd_seen = 0;
      repeat (20) begin
         step();
         if (rd === 1'b1) rd_seen++;
      end
      check("drained_no_rd", 32'(rd_seen), 32'd0);

      // rd_en low holds off reads; raising it reads at the next tick.
      rd_en = 1'b0;
      fifo_q.push_back(8'h5A);
      rd_seen = 0;
      repeat (20) begin
         step();
         if (rd === 1'b1) rd_seen++;
      end
      check("disabled_no_rd", 32'(rd_seen), 32'd0);
      rd_en = 1'b1;
      wait_rd("enable_rd", TICK_DIV + 2, n);
      step();
      check("enable_byte", 32'(last_byte), 32'h5A);

      // Reset during the READ cycle discards that read's update.
      fifo_q.push_back(8'h77);
      wait_rd("rst_read_rd", 12, n);
      rst = 1'b1;
      step();
      check("rst_in_read_count", 32'(rd_count),  32'h00);
      check("rst_in_read_byte",  32'(last_byte), 32'h00);
      check("rst_in_read_rd",    32'(rd),        32'd0);
      rst = 1'b0;
      repeat (6) step();

      // Count wrap: 256 reads from reset bring rd_count back to 0x00.
      rst = 1'b1;
      step();
      rst = 1'b0;
      rd_en = 1'b1;
      n = 0;
      for (int i = 0; i < 3000 && n < 256; i++) begin
         step();
         if (fifo_q.size() < 2) fifo_q.push_back(8'($urandom));
         if (rd === 1'b1) begin
            n++;
            if (n == 256) rd_en = 1'b0;
         end
      end
      check("wrap_reads", 32'(n), 32'd256);
      step();
      check("wrap_count", 32'(rd_count), 32'h00);
      wait_wei(4'b0100, 12);
      check("wrap_digit2", 32'(duan[6:0]), 32'h3F);
      wait_wei(4'b1000, 12);
      check("wrap_digit3", 32'(duan[6:0]), 32'h3F);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         step();
         rst   = ($urandom_range(0, 299) == 0);
         rd_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
      end
      rst = 1'b0;

      // Empty FIFO display phase (decimal point behaviour).
      rd_en = 1'b0;
      repeat (6) step();
      fifo_q.delete();
      repeat (16) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_reader_disp.md
FIFO_READER_DISP -- requirements
Module: fifo_reader_disp

Interface
REQ-001 Parameter TICK_DIV, default 100000000: clk cycles per read opportunity (>=4).
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles each display digit is driven (>=1).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rd_en  input  1  level enable for draining; low suppresses new reads.
REQ-006 empty  input  1  FIFO empty flag from upstream FIFO.
REQ-007 fifo_dout  input  8  FIFO show-ahead head data, valid whenever empty=0.
REQ-008 rd  output  1  one-cycle read strobe to FIFO.
REQ-009 last_byte  output  8  most recently consumed byte.
REQ-010 rd_count  output  8  number of bytes consumed, mod 256.
REQ-011 wei  output  4  digit select, one-hot, active-high.
REQ-012 duan  output  8  segments {dp,g,f,e,d,c,b,a}, active-high.

Function
REQ-013 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is asserted for exactly the cycle the counter equals TICK_DIV-1.
REQ-014 The tick counter SHALL free-run regardless of FSM state, rd_en, or empty.
REQ-015 FSM states SHALL be IDLE, READ, GAP.
REQ-016 IDLE->READ when tick=1 and rd_en=1 and empty=0 in the same cycle; otherwise the FSM SHALL remain in IDLE.
REQ-017 In READ, rd=1 for exactly that cycle; last_byte<=fifo_dout and rd_count<=rd_count+1 (8-bit wrap 255->0); next state GAP.
REQ-018 GAP SHALL last exactly 2 cycles, with rd=0, then return to IDLE, so the FIFO flags settle before the next read.
REQ-019 A tick arriving while in READ or GAP SHALL be dropped, not queued.
REQ-020 rd SHALL never be asserted outside READ; at most one byte is consumed per tick.
REQ-021 empty rising while in GAP SHALL have no effect; empty is sampled only in IDLE.
REQ-022 Scan counter SHALL advance the digit index 0->1->2->3->0 every SCAN_DIV cycles; wei=0001,0010,0100,1000 for index 0..3.
REQ-023 Digit 0 = last_byte[3:0], 1 = last_byte[7:4], 2 = rd_count[3:0], 3 = rd_count[7:4], each shown as a hex glyph 0-F.
REQ-024 Glyph map SHALL be standard 7-segment hex (e.g. 0 -> 0x3F, 1 -> 0x06, A -> 0x77, F -> 0x71 on duan[6:0]).
REQ-025 duan[7] (dp) SHALL be 0 except as set by REQ-031.
REQ-026 wei and duan SHALL be registered and update together on the same edge.

Reset
REQ-027 rst=1 at a clock edge SHALL force: state IDLE, tick counter 0, scan counter 0, digit index 0, rd=0, last_byte=0x00, rd_count=0x00.
REQ-028 After reset, wei=0001 and duan=0x3F (glyph 0).
REQ-029 Reset asserted while in READ SHALL take priority; the rd_count/last_byte update of that cycle is discarded.
REQ-030 rst SHALL have no asynchronous effect; its sensitivity is clk only.

Configuration
REQ-031 With macro FIFO_READER_EMPTY_DP_EN defined, duan[7] SHALL be 1 while digit 0 is selected and empty=1 (registered with duan). Without the macro, duan[7] is constant 0 and the empty input does not reach the display path.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-032 Reset, empty=1, rd_en=1 for 40 cycles -> rd never 1, rd_count=0x00, wei steps 0001->0010->0100->1000 every 2 cycles.
REQ-033 Preload FIFO with 0xA5,0x3C, rd_en=1 -> two single-cycle rd pulses 4 cycles apart, last_byte 0xA5 then 0x3C, rd_count 1 then 2, then no further rd after empty=1.
REQ-034 rd_en=0 with FIFO non-empty for 20 cycles -> no rd; set rd_en=1 -> first rd at the next tick.
REQ-035 Force rd_count to 0xFF, then one read -> rd_count=0x00; digit 3 and digit 2 duan = 0x3F.
REQ-036 Assert rst in the READ cycle -> rd_count=0x00, last_byte=0x00, FSM IDLE next cycle, no second rd.
REQ-037 With FIFO_READER_EMPTY_DP_EN and empty=1 -> duan[7]=1 only when wei=0001; without the macro, duan[7]=0 always.
